// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks: default count width and
// a saturating increment used by every spike counter.
package snn_pkg;

    localparam int SPIKE_CNT_W = 8;

    // Adds inc to value without exceeding max_value; callers truncate to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value,
                                            input logic        inc);
        if (inc && (value < max_value))
            return value + 32'd1;
        return value;
    endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for a spike level; the delayed copy samples every cycle
// so a frozen consumer never sees a phantom edge when it resumes.
module spike_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic spike,
    output logic spike_edge
);

    logic spike_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            spike_d <= 1'b0;
        else
            spike_d <= spike;
    end

    assign spike_edge = spike & ~spike_d;

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns a spike train back into numbers: per-window rising-edge count on a
// single-entry valid/ready buffer, plus the interval between the last two edges.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int CNT_W  = SPIKE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic [CNT_W-1:0] isi,
    output logic             isi_valid,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;
    localparam logic [31:0]      CNT_MAX  = 32'(CNT_ONES);

    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] since;
    logic             spike_edge;
    logic             close;
    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] result;

    spike_edge_detect u_edge (
        .clk        (clk),
        .rst        (rst),
        .spike      (spike),
        .spike_edge (spike_edge)
    );

    assign close  = en && (win_cnt == WIN_LAST);
    assign accept = rate_valid && rate_ready;
    assign drop   = close && rate_valid && !rate_ready;
    // The close cycle's own edge still belongs to the window being reported.
    assign result = CNT_W'(sat_inc(32'(spk_cnt), CNT_MAX, spike_edge));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt    <= '0;
            spk_cnt    <= '0;
            since      <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (en) begin
                win_cnt <= close ? '0 : win_cnt + 1'b1;
                spk_cnt <= close ? '0 : result;
                // since == 0 marks "no edge seen yet", so the first edge yields no interval.
                if (spike_edge) begin
                    if (since != '0) begin
                        isi       <= since;
                        isi_valid <= 1'b1;
                    end
                    since <= CNT_W'(1);
                end else if (since != '0) begin
                    since <= CNT_W'(sat_inc(32'(since), CNT_MAX, 1'b1));
                end
            end

            if (close && (!rate_valid || rate_ready)) begin
                rate       <= result;
                rate_valid <= 1'b1;
            end else if (accept && !close) begin
                rate_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule
